// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out stream bundle for the sliding-window generator.
// master = upstream producer + downstream consumer side, slave = the generator itself.
interface conv_window_gen_if #(
  parameter int K_H = 3,
  parameter int K_W = 3
);
  logic                            in_valid;
  logic                            in_ready;
  logic [7:0]                      in_pixel;
  logic                            out_valid;
  logic                            out_ready;
  logic [K_H-1:0][K_W-1:0][7:0]    out_win;
  logic                            out_last;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_win, out_last
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_win, out_last
  );
endinterface

// File: rtl/conv_window_gen.sv
// Raster-order pixel stream to K_H x K_W "valid" convolution windows, stride 1, one window per edge.
// Window registered 1 cycle after its last pixel is accepted; input stalls while an untaken window is held.
module conv_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K_H   = 3,
  parameter int K_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  conv_window_gen_if.slave io
);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef logic [K_H-1:0][7:0]          colv_t;
  typedef logic [K_H-1:0][K_W-1:0][7:0] win_t;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [7:0]       lb [K_H-1][IMG_W];
  win_t             win_q;
  win_t             win_nxt;
  colv_t            col_vec;
  logic             accept;
  logic             emit;
  logic             at_last_col;
  logic             at_last_row;

  assign io.in_ready  = !io.out_valid || io.out_ready;
  assign accept       = io.in_valid && io.in_ready;
  assign at_last_col  = (col == COL_W'(IMG_W - 1));
  assign at_last_row  = (row == ROW_W'(IMG_H - 1));
  assign emit         = accept && (row >= ROW_W'(K_H - 1)) && (col >= COL_W'(K_W - 1));

  // Line buffer k holds image row (row - K_H + 1 + k); the live pixel completes the column.
  always_comb begin
    col_vec = '0;
    win_nxt = '0;
    for (int k = 0; k < K_H - 1; k++) begin
      col_vec[k] = lb[k][col];
    end
    col_vec[K_H-1] = io.in_pixel;
    for (int i = 0; i < K_H; i++) begin
      for (int j = 0; j < K_W - 1; j++) begin
        win_nxt[i][j] = win_q[i][j+1];
      end
      win_nxt[i][K_W-1] = col_vec[i];
    end
  end

  // Storage is never cleared: the first K_H-1 rows of a frame are never emitted.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      win_q <= win_nxt;
      for (int k = 0; k < K_H - 2; k++) begin
        lb[k][col] <= lb[k+1][col];
      end
      lb[K_H-2][col] <= io.in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      io.out_valid <= 1'b0;
      io.out_last  <= 1'b0;
      io.out_win   <= '0;
    end else begin
      if (accept) begin
        if (at_last_col) begin
          col <= '0;
          row <= at_last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      // A new window may replace one being taken this edge; otherwise a taken window retires.
      if (emit) begin
        io.out_win   <= win_nxt;
        io.out_valid <= 1'b1;
        io.out_last  <= at_last_col && at_last_row;
      end else if (io.out_ready) begin
        io.out_valid <= 1'b0;
        io.out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: 4x4 and 28x28 instances against an index-arithmetic window model.
`timescale 1ns/1ps
module tb_conv_window_gen;
  typedef logic [2:0][2:0][7:0] win_t;
  typedef struct { win_t win; logic last; } exp_t;
  typedef struct { logic [7:0] pix; logic exp_vld; logic exp_last; win_t exp_win; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_gen_if #(.K_H(3), .K_W(3)) if4 ();
  conv_window_gen_if #(.K_H(3), .K_W(3)) if28 ();

  conv_window_gen #(.IMG_W(4), .IMG_H(4), .K_H(3), .K_W(3)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .io  (if4)
  );

  conv_window_gen #(.IMG_W(28), .IMG_H(28), .K_H(3), .K_W(3)) u_dut28 (
    .clk (clk),
    .rst (rst),
    .io  (if28)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t got4[$];
  exp_t got28[$];
  exp_t exp4[$];
  exp_t exp28[$];

  always @(negedge clk) begin
    if (!rst && if4.out_valid && if4.out_ready)
      got4.push_back('{win: if4.out_win, last: if4.out_last});
    if (!rst && if28.out_valid && if28.out_ready)
      got28.push_back('{win: if28.out_win, last: if28.out_last});
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: window at output position (r,c) is img[r-2+i][c-2+j].
  task automatic model_frame(input int w, input int h, input logic [7:0] img[$], input bit big);
    exp_t e;
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[i][j] = img[(r - 2 + i) * w + (c - 2 + j)];
        e.last = (r == h - 1) && (c == w - 1);
        if (big) exp28.push_back(e);
        else     exp4.push_back(e);
      end
    end
  endtask

  task automatic cmp_q(input string name, input bit big);
    exp_t e[$];
    exp_t g[$];
    if (big) begin
      e = exp28; g = got28; exp28.delete(); got28.delete();
    end else begin
      e = exp4;  g = got4;  exp4.delete();  got4.delete();
    end
    chk({name, " count"}, 128'(g.size()), 128'(e.size()));
    for (int i = 0; i < e.size() && i < g.size(); i++) begin
      chk($sformatf("%s win%0d", name, i), 128'(g[i].win), 128'(e[i].win));
      chk($sformatf("%s last%0d", name, i), 128'(g[i].last), 128'(e[i].last));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [7:0] p);
    int   n = 0;
    logic rdy;
    if4.in_pixel = p;
    if4.in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = if4.in_ready;
      step();
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL push4 timeout: pixel %0d not accepted, required accept within 200 cycles", p);
    end
  endtask

  task automatic push28(input logic [7:0] p);
    int   n = 0;
    logic rdy;
    if28.in_valid = 1'b0;
    while ($urandom_range(0, 1) == 1 && n < 8) begin
      if28.out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    n = 0;
    if28.in_pixel = p;
    if28.in_valid = 1'b1;
    do begin
      if28.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      rdy = if28.in_ready;
      step();
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL push28 timeout: pixel %0d not accepted, required accept within 200 cycles", p);
    end
  endtask

  task automatic send4(input logic [7:0] img[$]);
    if4.out_ready = 1'b1;
    foreach (img[k]) push4(img[k]);
    if4.in_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[16];
    logic [7:0] fr[$];
    logic [7:0] fr2[$];
    win_t       first_w;
    win_t       fifth_w;

    first_w = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    fifth_w = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};
    for (int k = 0; k < 16; k++) tbl[k] = '{pix: 8'(k), exp_vld: 1'b0, exp_last: 1'b0, exp_win: '0};
    tbl[10].exp_vld = 1'b1; tbl[10].exp_win = first_w;
    tbl[11].exp_vld = 1'b1; tbl[11].exp_win = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
    tbl[14].exp_vld = 1'b1; tbl[14].exp_win = {8'd14, 8'd13, 8'd12, 8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4};
    tbl[15].exp_vld = 1'b1; tbl[15].exp_win = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
    tbl[15].exp_last = 1'b1;

    if4.in_valid = 1'b0;  if4.in_pixel = '0;  if4.out_ready = 1'b1;
    if28.in_valid = 1'b0; if28.in_pixel = '0; if28.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 128'(if4.out_valid), 128'(0));
    chk("reset out_last", 128'(if4.out_last), 128'(0));
    chk("reset out_win", 128'(if4.out_win), 128'(0));
    chk("reset in_ready", 128'(if4.in_ready), 128'(1));
    chk("reset out_valid 28", 128'(if28.out_valid), 128'(0));
    step();

    // One pixel at a time: window must be visible exactly one edge after its last pixel.
    for (int k = 0; k < 16; k++) begin
      push4(tbl[k].pix);
      if4.in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("latency valid px%0d", k), 128'(if4.out_valid), 128'(tbl[k].exp_vld));
      if (tbl[k].exp_vld) begin
        chk($sformatf("latency win px%0d", k), 128'(if4.out_win), 128'(tbl[k].exp_win));
        chk($sformatf("latency last px%0d", k), 128'(if4.out_last), 128'(tbl[k].exp_last));
      end
      step();
    end
    got4.delete();

    // Stall the consumer for 5 cycles right after the first window.
    fr.delete();
    for (int k = 0; k < 16; k++) fr.push_back(8'(k));
    model_frame(4, 4, fr, 1'b0);
    if4.out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) push4(8'(k));
    if4.out_ready = 1'b0;
    if4.in_pixel  = 8'd11;
    if4.in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall in_ready c%0d", k), 128'(if4.in_ready), 128'(0));
      chk($sformatf("stall out_valid c%0d", k), 128'(if4.out_valid), 128'(1));
      chk($sformatf("stall out_win c%0d", k), 128'(if4.out_win), 128'(first_w));
      chk($sformatf("stall out_last c%0d", k), 128'(if4.out_last), 128'(0));
      step();
    end
    if4.out_ready = 1'b1;
    for (int k = 11; k < 16; k++) push4(8'(k));
    if4.in_valid = 1'b0;
    repeat (3) step();
    cmp_q("stall", 1'b0);

    // Back-to-back frames: second frame must not see first-frame pixels.
    fr2.delete();
    for (int k = 0; k < 16; k++) fr2.push_back(8'(100 + k));
    model_frame(4, 4, fr, 1'b0);
    model_frame(4, 4, fr2, 1'b0);
    send4({fr, fr2});
    chk("frame2 first window", got4.size() > 4 ? 128'(got4[4].win) : 128'(0), 128'(fifth_w));
    cmp_q("two frames", 1'b0);

    // Random input gaps and random consumer backpressure on the full-size ramp.
    fr.delete();
    for (int k = 0; k < 28 * 28; k++) fr.push_back(8'(k % 256));
    model_frame(28, 28, fr, 1'b1);
    foreach (fr[k]) push28(fr[k]);
    if28.in_valid  = 1'b0;
    if28.out_ready = 1'b1;
    repeat (5) step();
    cmp_q("ramp28", 1'b1);

    // A pending window is dropped by reset.
    if4.out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) push4(8'(k));
    if4.out_ready = 1'b0;
    if4.in_valid  = 1'b0;
    pulse_rst();
    @(negedge clk);
    chk("rst drop out_valid", 128'(if4.out_valid), 128'(0));
    chk("rst drop out_win", 128'(if4.out_win), 128'(0));
    chk("rst drop out_last", 128'(if4.out_last), 128'(0));
    step();
    if4.out_ready = 1'b1;
    chk("rst drop no window", 128'(got4.size()), 128'(0));
    got4.delete();

    // Reset after pixel 9, then a clean frame restarts at (0,0).
    fr.delete();
    for (int k = 0; k < 16; k++) fr.push_back(8'(k));
    for (int k = 0; k <= 9; k++) push4(8'(k));
    if4.in_valid = 1'b0;
    step();
    pulse_rst();
    step();
    chk("pre-restart windows", 128'(got4.size()), 128'(0));
    model_frame(4, 4, fr, 1'b0);
    send4(fr);
    cmp_q("restart", 1'b0);

    // Saturated pixels pass through unmodified.
    fr.delete();
    for (int k = 0; k < 16; k++) fr.push_back(8'd255);
    model_frame(4, 4, fr, 1'b0);
    send4(fr);
    cmp_q("all255", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Sliding-window generator directly upstream of the 3x3 convolution unit. Accepts an unsigned 8-bit pixel stream in raster order, buffers K_H-1 image rows, and emits one K_H x K_W window per valid output position ("valid" convolution, no padding, stride 1). Its window output connects directly to the convolution unit's window input. A valid/ready handshake on both sides gives full backpressure.

## Interface
- IMG_W, default 28: image width in pixels, at least K_W.
- IMG_H, default 28: image height in rows, at least K_H.
- K_H, default 3: window height.
- K_W, default 3: window width.
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_pixel is valid this cycle.
- in_ready  output  1  block accepts a pixel this cycle.
- in_pixel  input  8  unsigned pixel.
- out_valid  output  1  out_win holds a valid window.
- out_ready  input  1  consumer takes the window this cycle.
- out_win  output  8 x [K_H-1:0][K_W-1:0]  unsigned window. Element [i][j] is image pixel (r-K_H+1+i, c-K_W+1+j).
- out_last  output  1  high together with the final window of a frame.

## Operation
- A pixel is accepted when in_valid && in_ready.
- Column counter col counts 0..IMG_W-1. Row counter row counts 0..IMG_H-1. Both advance only on accept.
- Col wraps to 0 and increments row. At (IMG_H-1, IMG_W-1), both wrap to 0, and the next pixel starts a new frame.
- Line buffers: K_H-1 rows of IMG_W bytes each, indexed by col. On each accept:
  - The column vector {line buffers at col, in_pixel} shifts into the window register from the right, column K_W-1.
  - The line buffers shift down one row at col.
- Window emission: an accepted pixel at (row, col) with row >= K_H-1 and col >= K_W-1 produces a window.
  - The window is loaded into the output register on the same edge, and out_valid sets.
  - out_last = 1 if (row, col) = (IMG_H-1, IMG_W-1).
- All other accepts update storage only.
- Output count per frame: (IMG_H-K_H+1)*(IMG_W-K_W+1).
- Window columns 0..K_W-2 at row start hold stale data from the previous row. This is harmless because no window is emitted until col >= K_W-1.
- Line-buffer contents are never cleared. Rows 0..K_H-2 of each frame are never emitted, so data left over from a previous frame does not leak into output.
- No arithmetic is performed. Pixels pass through unmodified as unsigned 8-bit values; 255 stays 255.

## Timing
- Reset values: out_valid=0, out_last=0, out_win=0, col=0, row=0.
- in_ready is combinational: in_ready = !out_valid || out_ready. There is no combinational path from in_valid to in_ready.
- Latency: 1 cycle from accepting the pixel that completes a window to out_valid=1.
- While out_valid && !out_ready:
  - out_win and out_last are held stable.
  - in_ready=0, and no pixel is accepted.
- Simultaneous out_ready and an accept that completes a new window: the output register is overwritten and out_valid stays 1. Full throughput is 1 pixel/cycle.
- out_ready with no new window accepted: out_valid clears on the next edge.
- in_valid gaps: counters and storage freeze, and out_valid behaves per the handshake rules above.
- rst mid-frame: on the next edge, counters and the output register return to reset values and any pending window is dropped. The next accepted pixel is treated as (0,0) of a new frame. rst overrides any simultaneous accept.

## Test plan
- IMG_W=4, IMG_H=4, K=3x3, pixels 0..15, out_ready=1 -> exactly 4 windows.
  - First window rows {0,1,2},{4,5,6},{8,9,10}.
  - Last window {5,6,7},{9,10,11},{13,14,15} with out_last=1.
  - Each window appears 1 cycle after pixels 10, 11, 14, 15 are accepted.
- Same stimulus, out_ready=0 for 5 cycles after the first window -> out_win is held stable, in_ready=0, no pixels are lost, and the window sequence is identical.
- Two back-to-back 4x4 frames (second frame pixels 100..115) -> 8 windows. The fifth window is {100,101,102},{104,105,106},{108,109,110}, with no first-frame data.
- Random in_valid gaps (about 50%) on a 28x28 ramp image (pixel = (r*28+c) mod 256) -> 676 windows matching a reference model, with out_last only on the 676th.
- Assert rst after pixel 9 of a 4x4 frame, then send pixels 0..15 -> no window before the restart, then the 4 windows from the first scenario.
- All pixels 255 -> every window element is 255, confirming unsigned pass-through.
